// File: rtl/types.sv
// -----------------------------------------------------------------------------
// types
// Shared USB definitions for the device-side PHY control blocks.
//   USB_FULL_SPEED : 1 = 48 MHz full-speed build, 0 = 6 MHz low-speed build
//   CLK_PER_US     : clk cycles per microsecond for the configured speed
//   BIT_CLKS       : clk cycles per USB bit time
//   line_state_t   : abstract bus states driven onto D+/D-
//   bus_seq_state_t: states of the bus-signalling sequencer
//   line_drive()   : maps a line state to {dp,dn} for the configured speed
// -----------------------------------------------------------------------------
package types;

    localparam bit USB_FULL_SPEED = 1'b1;

    localparam int CLK_PER_US = (7 * int'(USB_FULL_SPEED) + 1) * 6;
    localparam int BIT_CLKS   = 4;

    typedef enum logic [1:0] {
        LS_SE0,
        LS_J,
        LS_K
    } line_state_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_SE0,
        ST_RES_K,
        ST_EOP_SE0,
        ST_EOP_J
    } bus_seq_state_t;

    // J is D+ high on full speed and D- high on low speed; K is its inverse.
    function automatic logic [1:0] line_drive(input line_state_t ls);
        logic [1:0] j_drive;
        logic [1:0] result;
        j_drive = USB_FULL_SPEED ? 2'b10 : 2'b01;
        case (ls)
            LS_J:    result = j_drive;
            LS_K:    result = ~j_drive;
            default: result = 2'b00;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/usb_bus_signal_tx_us_timer.sv
// -----------------------------------------------------------------------------
// usb_us_timer
// Microsecond interval timer: a prescaler divides clk down to 1 us and a
// down-counter counts the requested number of microseconds.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   load     : (re)start the interval; takes priority over counting
//   us_count : interval length in microseconds (must be >= 1)
//   tick     : combinational, high in the last clk cycle of the interval
// With load at edge n, tick is high in the (us_count*CLK_PER_US)-th cycle
// after edge n, so a consumer that changes state on tick sees an exact length.
// -----------------------------------------------------------------------------
module usb_us_timer
    import types::*;
#(
    parameter int CLK_PER_US_P = types::CLK_PER_US
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [14:0] us_count,
    output logic        tick
);

    localparam logic [5:0] PRESC_MAX = 6'(CLK_PER_US_P - 1);

    logic [5:0]  presc_q;
    logic [14:0] us_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            us_cnt_q <= '0;
        end else if (load) begin
            presc_q  <= PRESC_MAX;
            us_cnt_q <= us_count;
        end else if (us_cnt_q != 15'd0) begin
            // A zero microsecond count means the timer is parked.
            if (presc_q == 6'd0) begin
                presc_q  <= PRESC_MAX;
                us_cnt_q <= us_cnt_q - 15'd1;
            end else begin
                presc_q <= presc_q - 6'd1;
            end
        end
    end

    assign tick = (us_cnt_q == 15'd1) && (presc_q == 6'd0);

endmodule

// File: rtl/usb_bus_signal_tx.sv
// -----------------------------------------------------------------------------
// usb_bus_signal_tx
// Drives timed USB bus-state sequences onto the PHY: bus reset (long SE0,
// then one J bit time) and resume (long K, then a low-speed-style EOP of two
// SE0 bit times and one J bit time). Owns the PHY lines while busy.
//   clk        : system clock, CLK_PER_US MHz
//   reset_i    : asynchronous active-low reset
//   reset_req  : one-cycle request for a bus reset
//   resume_req : one-cycle request for a resume (loses to reset_req)
//   busy       : sequence in progress, lines owned here
//   done       : one-cycle pulse as a sequence completes
//   oe         : PHY output enable
//   dp, dn     : D+ / D- drive values (both 0 while oe=0)
// All outputs are registered; requests while busy are dropped.
// -----------------------------------------------------------------------------
module usb_bus_signal_tx
    import types::*;
#(
    parameter int RESET_US  = 10000,
    parameter int RESUME_US = 20000
) (
    input  logic clk,
    input  logic reset_i,
    input  logic reset_req,
    input  logic resume_req,
    output logic busy,
    output logic done,
    output logic oe,
    output logic dp,
    output logic dn
);

    localparam logic [14:0] RESET_US_W    = 15'(RESET_US);
    localparam logic [14:0] RESUME_US_W   = 15'(RESUME_US);
    localparam logic [3:0]  EOP_SE0_LOAD  = 4'(2 * BIT_CLKS - 1);
    localparam logic [3:0]  EOP_J_LOAD    = 4'(BIT_CLKS - 1);

    bus_seq_state_t state_q;
    bus_seq_state_t state_d;

    logic [3:0]  bit_cnt_q;
    logic        bit_zero;
    logic        tmr_load;
    logic [14:0] tmr_us;
    logic        tmr_tick;
    logic        done_d;
    logic        oe_d;
    logic [1:0]  line_d;
    line_state_t ls_d;

    usb_us_timer #(
        .CLK_PER_US_P (CLK_PER_US)
    ) u_us_timer (
        .clk      (clk),
        .rst_n    (reset_i),
        .load     (tmr_load),
        .us_count (tmr_us),
        .tick     (tmr_tick)
    );

    assign bit_zero = (bit_cnt_q == 4'd0);

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_us   = RESET_US_W;
        done_d   = 1'b0;
        ls_d     = LS_SE0;

        case (state_q)
            ST_IDLE: begin
                if (reset_req) begin
                    state_d  = ST_RST_SE0;
                    tmr_load = 1'b1;
                    tmr_us   = RESET_US_W;
                end else if (resume_req) begin
                    state_d  = ST_RES_K;
                    tmr_load = 1'b1;
                    tmr_us   = RESUME_US_W;
                end
            end
            ST_RST_SE0: if (tmr_tick) state_d = ST_EOP_J;
            ST_RES_K:   if (tmr_tick) state_d = ST_EOP_SE0;
            ST_EOP_SE0: if (bit_zero) state_d = ST_EOP_J;
            ST_EOP_J: begin
                if (bit_zero) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are computed from the next state so the registers present
        // the new line state in the same cycle the state takes effect.
        case (state_d)
            ST_RES_K: ls_d = LS_K;
            ST_EOP_J: ls_d = LS_J;
            default:  ls_d = LS_SE0;
        endcase

        oe_d   = (state_d != ST_IDLE);
        line_d = oe_d ? line_drive(ls_d) : 2'b00;
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
            oe      <= 1'b0;
            done    <= 1'b0;
            dp      <= 1'b0;
            dn      <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= oe_d;
            oe      <= oe_d;
            done    <= done_d;
            dp      <= line_d[1];
            dn      <= line_d[0];
        end
    end

    // Bit-time counter for the EOP phases; reloaded on every state entry so
    // each phase is exact regardless of how the previous one ended.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            bit_cnt_q <= '0;
        end else if (state_d != state_q) begin
            case (state_d)
                ST_EOP_SE0: bit_cnt_q <= EOP_SE0_LOAD;
                ST_EOP_J:   bit_cnt_q <= EOP_J_LOAD;
                default:    bit_cnt_q <= 4'd0;
            endcase
        end else if (!bit_zero) begin
            bit_cnt_q <= bit_cnt_q - 4'd1;
        end
    end

endmodule

// File: tb/tb_usb_bus_signal_tx.sv
`timescale 1ns/1ps
module tb_usb_bus_signal_tx;

    localparam bit FS          = types::USB_FULL_SPEED;
    localparam int CPU         = FS ? 48 : 6;
    localparam int RST_US      = 10;
    localparam int RES_US      = 5;
    localparam logic [1:0] J_V = FS ? 2'b10 : 2'b01;
    localparam logic [1:0] K_V = FS ? 2'b01 : 2'b10;
    localparam logic [1:0] SE0_V = 2'b00;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic reset_req = 1'b0;
    logic resume_req = 1'b0;
    logic busy, done, oe, dp, dn;

    usb_bus_signal_tx #(
        .RESET_US  (RST_US),
        .RESUME_US (RES_US)
    ) dut (
        .clk        (clk),
        .reset_i    (reset_i),
        .reset_req  (reset_req),
        .resume_req (resume_req),
        .busy       (busy),
        .done       (done),
        .oe         (oe),
        .dp         (dp),
        .dn         (dn)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Expected sequence: up to three (line value, length) segments.
    typedef struct packed {
        int               n;
        logic [2:0][1:0]  v;
        logic [2:0][31:0] l;
    } exp_t;

    exp_t exp_q[$];
    int compared   = 0;
    int mismatched = 0;
    int free_edge  = 0;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input bit is_reset);
        exp_t x;
        x = '0;
        if (is_reset) begin
            x.n = 2;
            x.v[0] = SE0_V; x.l[0] = 32'(RST_US * CPU);
            x.v[1] = J_V;   x.l[1] = 32'd4;
        end else begin
            x.n = 3;
            x.v[0] = K_V;   x.l[0] = 32'(RES_US * CPU);
            x.v[1] = SE0_V; x.l[1] = 32'd8;
            x.v[2] = J_V;   x.l[2] = 32'd4;
        end
        return x;
    endfunction

    // Drives one request pulse; the model accepts it only if the block is
    // idle at the sampling edge (sequence finished, done cycle included).
    task automatic issue(input logic r, input logic s);
        int e;
        exp_t x;
        @(posedge clk); #1;
        reset_req  = r;
        resume_req = s;
        e = edge_cnt + 1;
        if ((r || s) && e >= free_edge) begin
            x = model(r);
            exp_q.push_back(x);
            free_edge = e + int'(x.l[0]) + int'(x.l[1]) + int'(x.l[2]) + 1;
        end
        @(posedge clk); #1;
        reset_req  = 1'b0;
        resume_req = 1'b0;
    endtask

    task automatic wait_edge(input int target);
        while (edge_cnt < target) begin
            @(posedge clk); #1;
        end
    endtask

    // Request sampled exactly at edge 'target'.
    task automatic issue_at(input int target, input logic r, input logic s);
        wait_edge(target - 2);
        issue(r, s);
    endtask

    // Monitor: run-length encodes the lines while oe is high and checks the
    // whole sequence against the scoreboard when oe drops.
    logic [1:0] segv [3];
    int         segl [3];
    int         seg_n  = 0;
    bit         in_seq = 1'b0;

    task automatic compare_seq();
        exp_t x;
        if (exp_q.size() == 0) begin
            chk("unexpected_sequence_queue_size", exp_q.size(), 1);
            return;
        end
        x = exp_q.pop_front();
        chk("segment_count", seg_n, x.n);
        for (int i = 0; i < 3; i++) begin
            if (i < x.n && i < seg_n) begin
                chk($sformatf("seg%0d_value", i), int'(segv[i]), int'(x.v[i]));
                chk($sformatf("seg%0d_length", i), segl[i], int'(x.l[i]));
            end
        end
    endtask

    always @(negedge clk) begin
        logic [1:0] cur;
        cur = {dp, dn};
        if (!reset_i) begin
            in_seq = 1'b0;
            seg_n  = 0;
        end else begin
            chk("busy_equals_oe", int'(busy), int'(oe));
            if (oe) begin
                if (!in_seq) begin
                    in_seq  = 1'b1;
                    seg_n   = 1;
                    segv[0] = cur;
                    segl[0] = 1;
                end else if (seg_n <= 3 && cur == segv[seg_n-1]) begin
                    segl[seg_n-1]++;
                end else begin
                    if (seg_n < 3) begin
                        segv[seg_n] = cur;
                        segl[seg_n] = 1;
                    end
                    seg_n++;
                end
            end else begin
                chk("idle_lines", int'(cur), 0);
                if (in_seq) begin
                    chk("done_pulse", int'(done), 1);
                    compare_seq();
                    in_seq = 1'b0;
                end else begin
                    chk("done_while_idle", int'(done), 0);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int sel;
        #3 reset_i = 1'b0;
        #9;
        chk("reset_oe",   int'(oe),   0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_dpdn", int'({dp, dn}), 0);
        @(posedge clk); #1 reset_i = 1'b1;

        // Plain reset, then plain resume.
        issue(1'b1, 1'b0);
        wait_edge(free_edge + 2);
        issue(1'b0, 1'b1);
        wait_edge(free_edge + 2);

        // Simultaneous requests: reset only.
        issue(1'b1, 1'b1);
        wait_edge(free_edge + 3);

        // Resume 100 cycles into a reset is dropped; reset in the done cycle
        // is accepted.
        issue(1'b1, 1'b0);
        e0 = edge_cnt;
        issue_at(e0 + 100, 1'b0, 1'b1);
        issue_at(free_edge, 1'b1, 1'b0);
        wait_edge(free_edge + 2);

        // Asynchronous reset in the middle of RST_SE0.
        issue(1'b1, 1'b0);
        repeat (50) @(posedge clk);
        #2 reset_i = 1'b0;
        #1;
        chk("async_oe",   int'(oe),   0);
        chk("async_busy", int'(busy), 0);
        chk("async_done", int'(done), 0);
        exp_q.delete();
        free_edge = 0;
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b1;
        issue(1'b1, 1'b0);
        wait_edge(free_edge + 2);

        // Random requests, some landing while busy.
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 400)) @(posedge clk);
            sel = $urandom_range(0, 3);
            case (sel)
                0:       issue(1'b1, 1'b0);
                1:       issue(1'b0, 1'b1);
                2:       issue(1'b1, 1'b1);
                default: issue(1'b0, 1'b1);
            endcase
        end

        wait_edge(free_edge + 3);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
